// File: rtl/gpr_ctrl_pkg.sv
// Shared types for the GPR SRAM controller: FSM states, write-request payload, read-capture record.
package gpr_ctrl_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned WORD_COUNT_DFLT = 32;
  localparam int unsigned AW              = $clog2(WORD_COUNT_DFLT);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } wr_req_t;

  // Per read port, what was known at the request edge
  typedef struct packed {
    logic              valid;
    logic              hit;
    logic              zero;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wmask;
  } rd_cap_t;

  // SRAM returns the pre-write word on a same-cycle hit, so overlay the masked write bits
  function automatic logic [DATA_W-1:0] rd_result(input rd_cap_t c, input logic [DATA_W-1:0] q);
    if (!c.valid || c.zero) return '0;
    if (c.hit) return (c.wdata & c.wmask) | (q & ~c.wmask);
    return q;
  endfunction

endpackage

// File: rtl/gpr_wport_rr_arb.sv
// Round-robin arbiter for the shared SRAM write port; owns the rotating priority pointer.
module gpr_wport_rr_arb #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant_c,
  output logic [IW-1:0]   grant_idx_c,
  output logic            grant_any_c
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!grant_any_c && valid[cand]) begin
        grant_any_c = 1'b1;
        grant_idx_c = cand;
      end
    end
    if (grant_any_c) grant_c[grant_idx_c] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_any_c)
      ptr_d = (grant_idx_c == IW'(NREQ - 1)) ? '0 : grant_idx_c + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gpr_sram_ctrl.sv
// Controller for the 1W2R GPR SRAM: post-reset zero-fill, round-robin write port, bypassed reads.
// Build option GPR_ZERO_REG_EN makes address 0 a hardwired-zero register.
module gpr_sram_ctrl
  import gpr_ctrl_pkg::*;
#(
  parameter  int unsigned WORD_COUNT = 32,
  parameter  int unsigned NREQ       = 2,
  localparam int unsigned A_W        = $clog2(WORD_COUNT)
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  output logic                   INIT_DONE,
  input  logic [NREQ-1:0]        WREQ_VALID,
  output logic [NREQ-1:0]        WREQ_READY,
  input  logic [NREQ*A_W-1:0]    WREQ_ADDR,
  input  logic [NREQ*DATA_W-1:0] WREQ_DATA,
  input  logic [NREQ*DATA_W-1:0] WREQ_MASK,
  input  logic                   RD_EN_A,
  input  logic [A_W-1:0]         RD_ADDR_A,
  output logic [DATA_W-1:0]      RD_DATA_A,
  output logic                   RD_VALID_A,
  input  logic                   RD_EN_B,
  input  logic [A_W-1:0]         RD_ADDR_B,
  output logic [DATA_W-1:0]      RD_DATA_B,
  output logic                   RD_VALID_B,
  output logic                   SRAM_WEC,
  output logic [DATA_W-1:0]      SRAM_BWC,
  output logic [DATA_W-1:0]      SRAM_DC,
  output logic [A_W-1:0]         SRAM_AC,
  output logic                   SRAM_REA,
  output logic                   SRAM_REB,
  output logic [A_W-1:0]         SRAM_AA,
  output logic [A_W-1:0]         SRAM_AB,
  input  logic [DATA_W-1:0]      SRAM_QA,
  input  logic [DATA_W-1:0]      SRAM_QB
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state_q, state_d;
  logic [A_W-1:0] cnt_q, cnt_d;
  rd_cap_t        cap_a_q, cap_a_d, cap_b_q, cap_b_d;

  logic           run_c, sweep_c;
  wr_req_t        req_c [NREQ];
  wr_req_t        sel_c;
  logic [A_W-1:0] wr_addr_c;
  logic [IW-1:0]  grant_idx_c;
  logic           grant_any_c, wr_zero_c, wr_fire_c;

  assign run_c     = (state_q == ST_RUN);
  // Gated by RESETN so the write port goes idle the instant reset is asserted
  assign sweep_c   = (state_q == ST_INIT) && RESETN;
  assign INIT_DONE = run_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == A_W'(WORD_COUNT - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + A_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_c[i].addr = AW'(WREQ_ADDR[i*A_W +: A_W]);
      req_c[i].data = WREQ_DATA[i*DATA_W +: DATA_W];
      req_c[i].mask = WREQ_MASK[i*DATA_W +: DATA_W];
    end
  end

  gpr_wport_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk         (CLK),
    .rst_n       (RESETN),
    .valid       (WREQ_VALID & {NREQ{run_c}}),
    .advance     (run_c),
    .grant_c     (WREQ_READY),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  assign sel_c     = req_c[grant_idx_c];
  assign wr_addr_c = A_W'(sel_c.addr);
`ifdef GPR_ZERO_REG_EN
  assign wr_zero_c = (wr_addr_c == '0);
`else
  assign wr_zero_c = 1'b0;
`endif
  assign wr_fire_c = grant_any_c && !wr_zero_c;

  // Write port: zero-fill sweep, else the granted request
  always_comb begin
    SRAM_WEC = 1'b1;
    SRAM_BWC = '0;
    SRAM_DC  = '0;
    SRAM_AC  = '0;
    if (sweep_c) begin
      SRAM_WEC = 1'b0;
      SRAM_AC  = cnt_q;
    end else if (wr_fire_c) begin
      SRAM_WEC = 1'b0;
      SRAM_BWC = ~sel_c.mask;
      SRAM_DC  = sel_c.data;
      SRAM_AC  = wr_addr_c;
    end
  end

  assign SRAM_REA = ~(RD_EN_A & run_c);
  assign SRAM_REB = ~(RD_EN_B & run_c);
  assign SRAM_AA  = RD_ADDR_A;
  assign SRAM_AB  = RD_ADDR_B;

  always_comb begin
    cap_a_d       = '0;
    cap_a_d.valid = RD_EN_A & run_c;
    cap_a_d.hit   = cap_a_d.valid & wr_fire_c & (RD_ADDR_A == wr_addr_c);
    if (cap_a_d.hit) begin
      cap_a_d.wdata = sel_c.data;
      cap_a_d.wmask = sel_c.mask;
    end
    cap_b_d       = '0;
    cap_b_d.valid = RD_EN_B & run_c;
    cap_b_d.hit   = cap_b_d.valid & wr_fire_c & (RD_ADDR_B == wr_addr_c);
    if (cap_b_d.hit) begin
      cap_b_d.wdata = sel_c.data;
      cap_b_d.wmask = sel_c.mask;
    end
`ifdef GPR_ZERO_REG_EN
    cap_a_d.zero = cap_a_d.valid & (RD_ADDR_A == '0);
    cap_b_d.zero = cap_b_d.valid & (RD_ADDR_B == '0);
`endif
  end

  assign RD_VALID_A = cap_a_q.valid;
  assign RD_VALID_B = cap_b_q.valid;
  assign RD_DATA_A  = rd_result(cap_a_q, SRAM_QA);
  assign RD_DATA_B  = rd_result(cap_b_q, SRAM_QB);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      cap_a_q <= '0;
      cap_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_a_q <= cap_a_d;
      cap_b_q <= cap_b_d;
    end
  end

endmodule

// File: tb/tb_gpr_sram_ctrl.sv
// Randomized bench for gpr_sram_ctrl with an SRAM model and a register-file-level reference model.
module tb_gpr_sram_ctrl;

`ifdef GPR_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        INIT_DONE;
  logic [1:0]  WREQ_VALID, WREQ_READY;
  logic [9:0]  WREQ_ADDR;
  logic [63:0] WREQ_DATA, WREQ_MASK;
  logic        RD_EN_A, RD_EN_B, RD_VALID_A, RD_VALID_B;
  logic [4:0]  RD_ADDR_A, RD_ADDR_B;
  logic [31:0] RD_DATA_A, RD_DATA_B;
  logic        SRAM_WEC, SRAM_REA, SRAM_REB;
  logic [31:0] SRAM_BWC, SRAM_DC, SRAM_QA, SRAM_QB;
  logic [4:0]  SRAM_AC, SRAM_AA, SRAM_AB;

  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [31:0] wm [2];
  assign WREQ_ADDR = {wa[1], wa[0]};
  assign WREQ_DATA = {wd[1], wd[0]};
  assign WREQ_MASK = {wm[1], wm[0]};

  always #5 CLK = ~CLK;

  gpr_sram_ctrl #(.WORD_COUNT(32), .NREQ(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .INIT_DONE(INIT_DONE),
    .WREQ_VALID(WREQ_VALID), .WREQ_READY(WREQ_READY), .WREQ_ADDR(WREQ_ADDR),
    .WREQ_DATA(WREQ_DATA), .WREQ_MASK(WREQ_MASK),
    .RD_EN_A(RD_EN_A), .RD_ADDR_A(RD_ADDR_A), .RD_DATA_A(RD_DATA_A), .RD_VALID_A(RD_VALID_A),
    .RD_EN_B(RD_EN_B), .RD_ADDR_B(RD_ADDR_B), .RD_DATA_B(RD_DATA_B), .RD_VALID_B(RD_VALID_B),
    .SRAM_WEC(SRAM_WEC), .SRAM_BWC(SRAM_BWC), .SRAM_DC(SRAM_DC), .SRAM_AC(SRAM_AC),
    .SRAM_REA(SRAM_REA), .SRAM_REB(SRAM_REB), .SRAM_AA(SRAM_AA), .SRAM_AB(SRAM_AB),
    .SRAM_QA(SRAM_QA), .SRAM_QB(SRAM_QB)
  );

  // SRAM macro model: no reset (garbage at power-up), read returns the pre-write word
  logic [31:0] sram_mem [32];
  bit          seeded;
  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) sram_mem[i] <= $urandom;
      seeded <= 1'b1;
    end else begin
      if (!SRAM_REA) SRAM_QA <= sram_mem[SRAM_AA];
      if (!SRAM_REB) SRAM_QB <= sram_mem[SRAM_AB];
      if (!SRAM_WEC) sram_mem[SRAM_AC] <= (sram_mem[SRAM_AC] & SRAM_BWC) | (SRAM_DC & ~SRAM_BWC);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: logical register-file contents, priority pointer, pending read results
  logic [31:0] m_mem [32];
  bit          m_init;
  int          m_sweep, m_ptr;
  bit          m_rv_a, m_rv_b;
  logic [31:0] m_rd_a, m_rd_b;

  function automatic int exp_grant(input logic [1:0] v, input int ptr);
    for (int k = 0; k < 2; k++)
      if (v[(ptr + k) % 2]) return (ptr + k) % 2;
    return -1;
  endfunction

  function automatic logic [31:0] read_val(input logic [4:0] a);
    if (ZERO && a == 5'd0) return 32'h0;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_init = 1'b1; m_sweep = 0; m_ptr = 0;
    m_rv_a = 1'b0; m_rv_b = 1'b0; m_rd_a = 32'h0; m_rd_b = 32'h0;
  endtask

  task automatic model_update();
    int g;
    if (!RESETN) begin
      model_reset();
    end else if (m_init) begin
      if (m_sweep == 31) begin m_init = 1'b0; m_sweep = 0; end
      else m_sweep++;
      m_rv_a = 1'b0; m_rv_b = 1'b0; m_rd_a = 32'h0; m_rd_b = 32'h0;
    end else begin
      g = exp_grant(WREQ_VALID, m_ptr);
      if (g >= 0) begin
        m_ptr = (g + 1) % 2;
        if (!(ZERO && wa[g] == 5'd0))
          m_mem[wa[g]] = (m_mem[wa[g]] & ~wm[g]) | (wd[g] & wm[g]);
      end
      m_rv_a = RD_EN_A; m_rd_a = RD_EN_A ? read_val(RD_ADDR_A) : 32'h0;
      m_rv_b = RD_EN_B; m_rd_b = RD_EN_B ? read_val(RD_ADDR_B) : 32'h0;
    end
  endtask

  task automatic check_outputs();
    int g;
    bit wr;
    chk("aa", 32'(SRAM_AA), 32'(RD_ADDR_A));
    chk("ab", 32'(SRAM_AB), 32'(RD_ADDR_B));
    if (!RESETN) begin
      chk("init_done", 32'(INIT_DONE), 0); chk("ready", 32'(WREQ_READY), 0);
      chk("wec", 32'(SRAM_WEC), 1);
      chk("rv_a", 32'(RD_VALID_A), 0); chk("rv_b", 32'(RD_VALID_B), 0);
      chk("rd_a", RD_DATA_A, 0); chk("rd_b", RD_DATA_B, 0);
    end else if (m_init) begin
      chk("init_done", 32'(INIT_DONE), 0); chk("ready", 32'(WREQ_READY), 0);
      chk("wec", 32'(SRAM_WEC), 0); chk("ac", 32'(SRAM_AC), 32'(m_sweep));
      chk("bwc", SRAM_BWC, 0); chk("dc", SRAM_DC, 0);
      chk("rea", 32'(SRAM_REA), 1); chk("reb", 32'(SRAM_REB), 1);
      chk("rv_a", 32'(RD_VALID_A), 0); chk("rv_b", 32'(RD_VALID_B), 0);
      chk("rd_a", RD_DATA_A, 0); chk("rd_b", RD_DATA_B, 0);
    end else begin
      g  = exp_grant(WREQ_VALID, m_ptr);
      wr = (g >= 0) && !(ZERO && wa[g] == 5'd0);
      chk("init_done", 32'(INIT_DONE), 1);
      chk("ready", 32'(WREQ_READY), (g >= 0) ? 32'(1 << g) : 32'h0);
      chk("wec", 32'(SRAM_WEC), wr ? 32'h0 : 32'h1);
      chk("ac", 32'(SRAM_AC), wr ? 32'(wa[g]) : 32'h0);
      chk("dc", SRAM_DC, wr ? wd[g] : 32'h0);
      chk("bwc", SRAM_BWC, wr ? ~wm[g] : 32'h0);
      chk("rea", 32'(SRAM_REA), 32'(!RD_EN_A)); chk("reb", 32'(SRAM_REB), 32'(!RD_EN_B));
      chk("rv_a", 32'(RD_VALID_A), 32'(m_rv_a)); chk("rv_b", 32'(RD_VALID_B), 32'(m_rv_b));
      chk("rd_a", RD_DATA_A, m_rd_a); chk("rd_b", RD_DATA_B, m_rd_b);
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    WREQ_VALID = 2'b00; RD_EN_A = 1'b0; RD_EN_B = 1'b0;
    RD_ADDR_A = 5'd0; RD_ADDR_B = 5'd0;
    for (int i = 0; i < 2; i++) begin wa[i] = 5'd0; wd[i] = 32'h0; wm[i] = 32'h0; end
  endtask

  task automatic rand_inputs();
    WREQ_VALID = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      wa[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wd[i] = $urandom;
      case ($urandom_range(0, 2))
        0:       wm[i] = 32'hFFFF_FFFF;
        1:       wm[i] = 32'h0000_FFFF;
        default: wm[i] = $urandom;
      endcase
    end
    RD_EN_A = 1'($urandom); RD_ADDR_A = 5'($urandom_range(0, 7));
    RD_EN_B = 1'($urandom); RD_ADDR_B = 5'($urandom_range(0, 7));
  endtask

  task automatic wait_init(input string name);
    for (int i = 0; i < 40 && !INIT_DONE; i++) cycle();
    chk(name, 32'(INIT_DONE), 1);
  endtask

  initial begin
    int n;
    RESETN = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) cycle();
    RESETN = 1'b1;
    #1;

    // zero-fill length, then a read of a swept entry
    n = 0;
    for (int i = 0; i < 40 && !INIT_DONE; i++) begin
      if (SRAM_WEC == 1'b0) n++;
      cycle();
    end
    chk("init_len", 32'(n), 32);
    chk("init_done_lit", 32'(INIT_DONE), 1);
    RD_EN_A = 1'b1; RD_ADDR_A = 5'd7;
    cycle();
    chk("rd7_valid", 32'(RD_VALID_A), 1);
    chk("rd7_data", RD_DATA_A, 32'h0);
    RD_EN_A = 1'b0;

    // round-robin: alternate with both valid, single requester always wins
    wa[0] = 5'd20; wa[1] = 5'd21; wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0000;
    wm[0] = 32'hFFFF_FFFF; wm[1] = 32'hFFFF_FFFF;
    WREQ_VALID = 2'b11; #1;
    chk("rr0", 32'(WREQ_READY), 32'h1); cycle();
    chk("rr1", 32'(WREQ_READY), 32'h2); cycle();
    chk("rr2", 32'(WREQ_READY), 32'h1); cycle();
    chk("rr3", 32'(WREQ_READY), 32'h2); cycle();
    WREQ_VALID = 2'b10; #1;
    chk("single0", 32'(WREQ_READY), 32'h2); cycle();
    chk("single1", 32'(WREQ_READY), 32'h2); cycle();
    idle_inputs();

    // same-cycle write/read bypass, full mask
    WREQ_VALID = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF; wm[0] = 32'hFFFF_FFFF;
    RD_EN_A = 1'b1; RD_ADDR_A = 5'd5;
    cycle();
    chk("byp_valid", 32'(RD_VALID_A), 1);
    chk("byp_data", RD_DATA_A, 32'hDEAD_BEEF);
    idle_inputs();

    // partial-mask bypass seen by both ports
    WREQ_VALID = 2'b10; wa[1] = 5'd9; wd[1] = 32'h1234_5678; wm[1] = 32'hFFFF_FFFF;
    cycle();
    wd[1] = 32'hAAAA_AAAA; wm[1] = 32'h0000_FFFF;
    RD_EN_A = 1'b1; RD_ADDR_A = 5'd9; RD_EN_B = 1'b1; RD_ADDR_B = 5'd9;
    cycle();
    chk("mask_a", RD_DATA_A, 32'h1234_AAAA);
    chk("mask_b", RD_DATA_B, 32'h1234_AAAA);
    idle_inputs();

    // address 0 write then read
    WREQ_VALID = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1; wm[0] = 32'hFFFF_FFFF;
    #1;
    chk("z_ready", 32'(WREQ_READY), 32'h1);
`ifdef GPR_ZERO_REG_EN
    chk("z_wec", 32'(SRAM_WEC), 32'h1);
`else
    chk("z_wec", 32'(SRAM_WEC), 32'h0);
`endif
    cycle();
    idle_inputs();
    RD_EN_A = 1'b1; RD_ADDR_A = 5'd0;
    cycle();
    chk("z_valid", 32'(RD_VALID_A), 1);
`ifdef GPR_ZERO_REG_EN
    chk("z_data", RD_DATA_A, 32'h0);
`else
    chk("z_data", RD_DATA_A, 32'h1);
`endif
    idle_inputs();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle();
    end
    idle_inputs();

    // reset mid-sweep restarts at 0
    RESETN = 1'b0; #1;
    chk("rst_wec", 32'(SRAM_WEC), 1);
    cycle();
    RESETN = 1'b1; #1;
    repeat (10) cycle();
    chk("sweep10_ac", 32'(SRAM_AC), 32'd10);
    RESETN = 1'b0; #1;
    chk("mid_rst_wec", 32'(SRAM_WEC), 1);
    chk("mid_rst_done", 32'(INIT_DONE), 0);
    repeat (2) cycle();
    RESETN = 1'b1; #1;
    chk("restart_ac", 32'(SRAM_AC), 32'd0);
    chk("restart_wec", 32'(SRAM_WEC), 32'd0);
    wait_init("reinit_done");
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      cycle();
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
